tsp_coord_loader: RTL and testbench
===================================

// Module: tsp_coord_loader
// PURPOSE
//  Writer end of the solver's city-coordinate interface: parses a framed byte
//  stream (from the board UART receiver) into the xs/ys coordinate arrays that
//  the tsp solver reads.
//  Signals the solver to restart once a frame passes its checksum.
//  Sits between uart_rx and tsp inside the top-level board wrapper.
// PARAMETERS
//  NCITY    64        max cities; array depth; IDX_W = $clog2(NCITY)
//  COORD_W  8         coordinate width in bits (one byte per coordinate)
//  HDR      8'hA5     frame start byte
//  TIMEOUT  50_000    max idle clocks between bytes inside a frame
// PORTS
//  clk         in   1        system clock
//  rst         in   1        async reset, active high
//  in_data     in   8        received byte
//  in_valid    in   1        in_data valid; byte accepted when in_valid&&in_ready
//  in_ready    out  1        loader can accept a byte
//  xs          out  8 x64    city x coords, xs[i]
//  ys          out  8 x64    city y coords, ys[i]
//  n_cities    out  7        city count of last good frame (1..64)
//  coord_valid out  1        xs/ys/n_cities hold a complete, checked frame
//  solver_rst  out  1        1-cycle pulse to restart tsp after a good frame
//  err         out  1        1-cycle pulse on any frame error
// BEHAVIOUR
//  Reset (async): state=IDLE; xs/ys all 0; n_cities=0; coord_valid=0;
//   solver_rst=0; err=0; in_ready=0 while rst high, 1 first cycle after.
//  Frame: HDR, N, then N pairs (x0,y0)..(xN-1,yN-1), then CSUM.
//   CSUM = 8-bit wrap-around sum of N and all 2N coordinate bytes.
//  FSM (advances only on accepted bytes, except DONE and timeout):
//   IDLE  byte==HDR -> COUNT; any other byte is discarded, no err.
//   COUNT N in 1..NCITY: latch N, idx=0, sum=N, coord_valid<=0,
//         clear xs/ys to 0 in the same cycle -> XB.
//         N==0 or N>NCITY: err pulse -> IDLE.
//   XB    xs[idx]<=byte, sum+=byte -> YB.
//   YB    ys[idx]<=byte, sum+=byte; idx==N-1 -> CSUM, else idx++ -> XB.
//   CSUM  byte==sum: n_cities<=N -> DONE.
//         byte!=sum: err pulse, coord_valid stays 0 -> IDLE.
//   DONE  single cycle, in_ready=0: coord_valid<=1, solver_rst=1 -> IDLE.
//  in_ready = 1 in every state except DONE.
//  Bytes are written directly into xs/ys (no shadow copy). A failed or
//   aborted frame leaves partial data with coord_valid=0. Entries at
//   idx >= N stay 0.
//  HDR byte inside a frame is treated as data, not a resync.
//  Timeout: idle counter cleared on each accepted byte. In
//   COUNT/XB/YB/CSUM, counter reaching TIMEOUT -> err pulse -> IDLE.
//   Counter held at 0 in IDLE.
//  Latency: last (CSUM) byte accepted at cycle t -> DONE at t+1
//   -> coord_valid=1 and solver_rst pulse visible at t+2.
//  err and solver_rst are never high in the same cycle.
//  Reset mid-frame: immediate return to reset values; no pulse generated.
// STRUCTURE
//  tsp_pkg: NCITY, COORD_W, IDX_W, HDR, state enum
//   ld_state_t {IDLE,COUNT,XB,YB,CSUM,DONE}.
//  Single module, no sub-module. The idle timeout counter is inline.
//  xs/ys are flop arrays: the solver reads all entries in parallel.
// TESTING
//  1. Frame A5 02 10 20 30 40 A2 -> xs[0]=10,ys[0]=20,xs[1]=30,ys[1]=40,
//     n_cities=2, coord_valid=1 and 1-cycle solver_rst exactly 2 clks after
//     the A2 byte; entries 2..63 read 0.
//  2. Same frame with CSUM A3 -> 1 err pulse, coord_valid=0, no solver_rst,
//     next good frame accepted.
//  3. Count bytes 00 and 41 -> err pulse each, back to IDLE; leading junk
//     12 34 before A5 ignored with no err.
//  4. N=64 frame with xi=i, yi=255-i, sum wraps mod 256 -> all 128 entries
//     correct, n_cities=64.
//  5. Stall TIMEOUT clks after the 3rd data byte -> err pulse, FSM in IDLE;
//     stall TIMEOUT-1 clks -> frame completes normally.
//  6. Assert rst mid-frame (async, between edges) -> outputs zero at once,
//     no err; full frame after release loads correctly.

Source files
------------

// File: rtl/tsp_pkg.sv
// Shared constants and state type for the tsp solver's coordinate interface.
package tsp_pkg;

  localparam int         NCITY   = 64;
  localparam int         COORD_W = 8;
  localparam int         IDX_W   = $clog2(NCITY);
  localparam logic [7:0] HDR     = 8'hA5;
  localparam int         TIMEOUT = 50_000;

  // Frame parser states: header hunt, count byte, x/y coordinate bytes,
  // checksum byte, and a one-cycle commit state.
  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    XB,
    YB,
    CSUM,
    DONE
  } ld_state_t;

endpackage

// File: rtl/tsp_coord_loader.sv
// Framed byte-stream parser that loads city coordinates for the tsp solver.
// Frame: HDR, N, x0, y0, .., xN-1, yN-1, CSUM (8-bit sum of N and all coords).
// Coordinates land directly in the xs/ys flop arrays; coord_valid and a
// solver_rst pulse follow only a frame whose checksum matches.
module tsp_coord_loader #(
  parameter int         NCITY   = tsp_pkg::NCITY,
  parameter int         COORD_W = tsp_pkg::COORD_W,
  parameter logic [7:0] HDR     = tsp_pkg::HDR,
  parameter int         TIMEOUT = tsp_pkg::TIMEOUT,
  localparam int        IDX_W   = $clog2(NCITY)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [COORD_W-1:0] xs [NCITY],
  output logic [COORD_W-1:0] ys [NCITY],
  output logic [IDX_W:0]     n_cities,
  output logic               coord_valid,
  output logic               solver_rst,
  output logic               err
);

  import tsp_pkg::*;

  localparam int             TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  ld_state_t        state;
  logic [IDX_W:0]   n_lat;     // city count of the frame in progress
  logic [IDX_W-1:0] idx;       // city currently being written
  logic [7:0]       sum;       // running checksum
  logic [TO_W-1:0]  idle_cnt;  // clocks since the last accepted byte
  logic             accept;

  // A byte is consumed only when both sides agree on the handshake.
  assign accept = in_valid && in_ready;

  // Frame parser: state, coordinate arrays, idle timeout and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      n_lat       <= '0;
      idx         <= '0;
      sum         <= '0;
      idle_cnt    <= '0;
      in_ready    <= 1'b0;
      coord_valid <= 1'b0;
      solver_rst  <= 1'b0;
      err         <= 1'b0;
      n_cities    <= '0;
      // NOTE: xs/ys are flop arrays read in parallel by the solver, so they
      // are reset like any other output rather than left as an unreset RAM.
      for (int i = 0; i < NCITY; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees the
      // pre-edge values and later assignments cleanly override the defaults.
      err        <= 1'b0;
      solver_rst <= 1'b0;
      in_ready   <= 1'b1;

      // Inter-byte idle timeout, only while a frame is being received.
      if (state != IDLE && state != DONE) begin
        if (accept) begin
          idle_cnt <= '0;
        end else if (idle_cnt == TO_LAST) begin
          idle_cnt <= '0;
          err      <= 1'b1;
          state    <= IDLE;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end

      case (state)
        IDLE: begin
          // Anything other than the header byte is silently dropped.
          if (accept && in_data == HDR) state <= COUNT;
        end

        COUNT: begin
          if (accept) begin
            if (in_data == 8'd0 || int'(in_data) > NCITY) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              n_lat       <= (IDX_W+1)'(in_data);
              idx         <= '0;
              sum         <= in_data;
              coord_valid <= 1'b0;
              for (int i = 0; i < NCITY; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
              end
              state <= XB;
            end
          end
        end

        XB: begin
          if (accept) begin
            xs[idx] <= COORD_W'(in_data);
            sum     <= sum + in_data;
            state   <= YB;
          end
        end

        YB: begin
          if (accept) begin
            ys[idx] <= COORD_W'(in_data);
            sum     <= sum + in_data;
            if ({1'b0, idx} == n_lat - 1'b1) begin
              state <= CSUM;
            end else begin
              idx   <= idx + 1'b1;
              state <= XB;
            end
          end
        end

        CSUM: begin
          if (accept) begin
            if (in_data == sum) begin
              n_cities <= n_lat;
              in_ready <= 1'b0;
              state    <= DONE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end

        DONE: begin
          // Commit cycle: publish the frame and kick the solver.
          coord_valid <= 1'b1;
          solver_rst  <= 1'b1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsp_coord_loader.sv
// Self-checking bench for tsp_coord_loader: directed frames plus random
// traffic, compared every cycle against a frame-level model of the loader.
module tb_tsp_coord_loader;

  import tsp_pkg::*;

  localparam int TB_TO = 40;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       xs [NCITY];
  logic [7:0]       ys [NCITY];
  logic [IDX_W:0]   n_cities;
  logic             coord_valid;
  logic             solver_rst;
  logic             err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tsp_coord_loader #(.TIMEOUT(TB_TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .xs         (xs),
    .ys         (ys),
    .n_cities   (n_cities),
    .coord_valid(coord_valid),
    .solver_rst (solver_rst),
    .err        (err)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame level) ----------------
  logic [7:0] exp_xs [NCITY];
  logic [7:0] exp_ys [NCITY];
  logic [6:0] exp_n;
  logic       exp_cv, exp_srst, exp_err, exp_rdy;
  logic [7:0] q [$];     // bytes of the current frame after the header
  bit         in_frame;
  bit         done_pending;
  int         idle_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCITY; i++) begin
        exp_xs[i] = '0;
        exp_ys[i] = '0;
      end
      exp_n = '0; exp_cv = 0; exp_srst = 0; exp_err = 0; exp_rdy = 0;
      q.delete(); in_frame = 0; done_pending = 0; idle_m = 0;
    end else begin
      bit acc;
      acc      = in_valid && exp_rdy;
      exp_err  = 0;
      exp_srst = 0;
      if (done_pending) begin
        done_pending = 0;
        exp_cv       = 1;
        exp_srst     = 1;
      end else if (!in_frame) begin
        if (acc && in_data == HDR) begin
          in_frame = 1;
          q.delete();
          idle_m = 0;
        end
      end else if (acc) begin
        idle_m = 0;
        if (q.size() == 0) begin
          int n;
          n = in_data;
          if (n == 0 || n > NCITY) begin
            exp_err  = 1;
            in_frame = 0;
          end else begin
            q.push_back(in_data);
            exp_cv = 0;
            for (int i = 0; i < NCITY; i++) begin
              exp_xs[i] = '0;
              exp_ys[i] = '0;
            end
          end
        end else if (q.size() == 1 + 2 * int'(q[0])) begin
          int s;
          s = 0;
          foreach (q[i]) s += q[i];
          if ((s % 256) == int'(in_data)) begin
            exp_n        = q[0][6:0];
            done_pending = 1;
          end else begin
            exp_err = 1;
          end
          in_frame = 0;
        end else begin
          int j;
          j = q.size() - 1;
          if (j % 2 == 0) exp_xs[j/2] = in_data;
          else            exp_ys[j/2] = in_data;
          q.push_back(in_data);
        end
      end else begin
        idle_m++;
        if (idle_m == TB_TO) begin
          exp_err  = 1;
          in_frame = 0;
        end
      end
      exp_rdy = !done_pending;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int bad;
    check("in_ready",    in_ready,    exp_rdy);
    check("err",         err,         exp_err);
    check("solver_rst",  solver_rst,  exp_srst);
    check("coord_valid", coord_valid, exp_cv);
    check("n_cities",    n_cities,    exp_n);
    bad = -1;
    for (int i = 0; i < NCITY; i++)
      if (bad < 0 && (xs[i] !== exp_xs[i] || ys[i] !== exp_ys[i])) bad = i;
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL xs_ys[%0d]: got x=%0h y=%0h expected x=%0h y=%0h at %0t",
               bad, xs[bad], ys[bad], exp_xs[bad], exp_ys[bad], $time);
    end
    if (err && solver_rst) check("err_and_solver_rst_exclusive", 1, 0);
  end

  // ---------------- drivers ----------------
  logic [7:0] tx_q [$];

  // Offer one byte, waiting (bounded) until the loader is ready.
  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 8) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Offer one byte for exactly one cycle whether or not the loader is ready.
  task automatic raw(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
  endtask

  task automatic send_tx();
    foreach (tx_q[i]) send(tx_q[i]);
  endtask

  task automatic frame_a(input logic [7:0] cs);
    tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40};
    tx_q.push_back(cs);
    send_tx();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_n_cities", n_cities, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: basic good frame, commit latency of two clocks after CSUM.
    frame_a(8'hA2);
    @(negedge clk);
    check("t1_srst_t1", solver_rst, 0);
    check("t1_cv_t1",   coord_valid, 0);
    check("t1_rdy_done", in_ready, 0);
    @(negedge clk);
    check("t1_srst_t2", solver_rst, 1);
    check("t1_cv_t2",   coord_valid, 1);
    @(negedge clk);
    check("t1_srst_pulse_end", solver_rst, 0);
    check("t1_xs0", xs[0], 8'h10);
    check("t1_ys0", ys[0], 8'h20);
    check("t1_xs1", xs[1], 8'h30);
    check("t1_ys1", ys[1], 8'h40);
    check("t1_xs2", xs[2], 0);
    check("t1_ys63", ys[63], 0);
    check("t1_n",   n_cities, 2);

    // 2: bad checksum, then a good frame recovers.
    frame_a(8'hA3);
    @(negedge clk);
    check("t2_err", err, 1);
    check("t2_cv",  coord_valid, 0);
    @(negedge clk);
    check("t2_err_pulse_end", err, 0);
    frame_a(8'hA2);
    repeat (2) @(negedge clk);
    check("t2_recover_cv", coord_valid, 1);

    // 3: junk ignored, illegal counts rejected.
    send(8'h12);
    send(8'h34);
    send(8'hA5);
    send(8'h00);
    @(negedge clk);
    check("t3_err_n0", err, 1);
    send(8'hA5);
    send(8'h41);
    @(negedge clk);
    check("t3_err_n65", err, 1);
    check("t3_n_kept", n_cities, 2);

    // 4: full 64-city frame; checksum wraps to 00.
    tx_q = '{8'hA5, 8'h40};
    for (int i = 0; i < 64; i++) begin
      tx_q.push_back(8'(i));
      tx_q.push_back(8'(255 - i));
    end
    tx_q.push_back(8'h00);
    send_tx();
    repeat (2) @(negedge clk);
    check("t4_cv",   coord_valid, 1);
    check("t4_n",    n_cities, 64);
    check("t4_ys0",  ys[0], 8'hFF);
    check("t4_xs63", xs[63], 8'h3F);
    check("t4_ys63", ys[63], 8'hC0);

    // 5: stall of TIMEOUT aborts; stalls of TIMEOUT-1 do not.
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_tx();
    idle(TB_TO);
    @(negedge clk);
    check("t5_timeout_err", err, 1);
    check("t5_cv_cleared",  coord_valid, 0);
    send(8'h44);
    send(8'hA5);
    send(8'h01);
    idle(TB_TO - 1);
    send(8'h55);
    idle(TB_TO - 1);
    send(8'h66);
    idle(TB_TO - 1);
    send(8'hBC);
    repeat (2) @(negedge clk);
    check("t5_slow_cv",  coord_valid, 1);
    check("t5_slow_n",   n_cities, 1);
    check("t5_slow_xs0", xs[0], 8'h55);
    check("t5_slow_xs1", xs[1], 0);

    // 6: asynchronous reset mid-frame.
    tx_q = '{8'hA5, 8'h02, 8'h10};
    send_tx();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_cv",  coord_valid, 0);
    check("t6_xs0", xs[0], 0);
    check("t6_n",   n_cities, 0);
    check("t6_err", err, 0);
    check("t6_rdy", in_ready, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    frame_a(8'hA2);
    repeat (2) @(negedge clk);
    check("t6_reload_cv",  coord_valid, 1);
    check("t6_reload_ys1", ys[1], 8'h40);

    // Random traffic: junk, legal/illegal counts, bad sums, gaps, timeouts.
    for (int f = 0; f < 60; f++) begin
      int n, r;
      int s;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        raw(8'($urandom_range(0, 255)));
      end else begin
        if (r == 1)      n = 0;
        else if (r == 2) n = $urandom_range(65, 255);
        else if (r == 3) n = 64;
        else             n = $urandom_range(1, 6);
        tx_q = '{8'hA5};
        tx_q.push_back(8'(n));
        s = n;
        if (n >= 1 && n <= NCITY) begin
          for (int i = 0; i < 2 * n; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 7) == 0) ? HDR : 8'($urandom_range(0, 255));
            tx_q.push_back(b);
            s += b;
          end
          tx_q.push_back(($urandom_range(0, 4) == 0) ? 8'(s + 1) : 8'(s));
        end
        foreach (tx_q[i]) begin
          raw(tx_q[i]);
          r = $urandom_range(0, 39);
          if (r == 0)      idle(TB_TO);
          else if (r < 10) idle($urandom_range(1, 3));
        end
        if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
      end
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
